// File: rtl/dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_port_arbiter
//
// Shares one single-port data memory (registered read, 1-cycle latency)
// between two requesters: m0 (CPU load/store path) and m1 (debug/loader).
// After reset an init sequencer zero-fills words 0..INIT_WORDS-1. After that
// at most one access is granted per cycle. Read data is passed straight
// through from the memory. A one-cycle valid strobe marks the read data for
// whichever requester issued the read.
//
// Optional feature macro:
//   DMEM_ARB_RR_EN  defined   -> round-robin arbitration (1-bit last-grant pointer)
//                   undefined -> fixed priority, m0 always wins
//
// Ports:
//   clk, resetn                      clock, synchronous active-low reset
//   i_mX_req/we/addr/wd              requester X access (hold until o_mX_gnt)
//   o_mX_gnt                         comb., access accepted this cycle
//   o_mX_rvalid                      reg., o_rd_data holds requester X read result
//   o_rd_data                        read data (pass-through of i_mem_rd)
//   o_mem_we/addr/wd                 comb., memory write enable/address/data
//   i_mem_rd                         memory read data (1 cycle after address)
//   o_init_done                      reg., zero-fill complete
// ---------------------------------------------------------------------------
module dmem_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9,
    parameter int INIT_WORDS = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  i_m0_req,
    input  logic                  i_m0_we,
    input  logic [ADDR_WIDTH-1:0] i_m0_addr,
    input  logic [DATA_WIDTH-1:0] i_m0_wd,
    output logic                  o_m0_gnt,
    output logic                  o_m0_rvalid,
    input  logic                  i_m1_req,
    input  logic                  i_m1_we,
    input  logic [ADDR_WIDTH-1:0] i_m1_addr,
    input  logic [DATA_WIDTH-1:0] i_m1_wd,
    output logic                  o_m1_gnt,
    output logic                  o_m1_rvalid,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wd,
    input  logic [DATA_WIDTH-1:0] i_mem_rd,
    output logic                  o_init_done
);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    // One bit wider than the address so INIT_WORDS = 2**ADDR_WIDTH fits.
    localparam logic [ADDR_WIDTH:0] INIT_LIMIT = (ADDR_WIDTH+1)'(INIT_WORDS);

    state_t                r_state;
    logic [ADDR_WIDTH:0]   r_init_cnt;
    logic                  r_init_done;
    logic                  r_m0_rvalid;
    logic                  r_m1_rvalid;
    logic [ADDR_WIDTH-1:0] r_last_addr;

    logic                  w_run;
    logic                  w_gnt0;
    logic                  w_gnt1;
    logic                  w_init_wr;
    logic                  w_init_last;

    assign w_run = resetn && (r_state == ST_RUN);

    // With nothing to clear the sequencer spends exactly one idle cycle in
    // INIT; otherwise it writes every INIT cycle and leaves after the last word.
    generate
        if (INIT_WORDS == 0) begin : g_no_init
            assign w_init_wr   = 1'b0;
            assign w_init_last = 1'b1;
        end else begin : g_init
            assign w_init_wr   = resetn && (r_state == ST_INIT);
            assign w_init_last = (r_init_cnt == INIT_LIMIT - 1'b1);
        end
    endgenerate

`ifdef DMEM_ARB_RR_EN
    // 1 = m1 has priority on the next conflict (m0 was granted last).
    logic r_rr_m1_first;

    assign w_gnt0 = w_run && i_m0_req && (!i_m1_req || !r_rr_m1_first);
    assign w_gnt1 = w_run && i_m1_req && (!i_m0_req ||  r_rr_m1_first);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rr_m1_first <= 1'b0;
        end else if (w_gnt0) begin
            r_rr_m1_first <= 1'b1;
        end else if (w_gnt1) begin
            r_rr_m1_first <= 1'b0;
        end
    end
`else
    assign w_gnt0 = w_run && i_m0_req;
    assign w_gnt1 = w_run && i_m1_req && !i_m0_req;
`endif

    assign o_m0_gnt = w_gnt0;
    assign o_m1_gnt = w_gnt1;

    // Memory-side mux. When idle the address is held so the memory's read
    // register keeps returning the last addressed word.
    always_comb begin
        o_mem_we   = 1'b0;
        o_mem_addr = r_last_addr;
        o_mem_wd   = '0;
        if (!resetn) begin
            o_mem_addr = '0;
        end else if (w_init_wr) begin
            o_mem_we   = 1'b1;
            o_mem_addr = r_init_cnt[ADDR_WIDTH-1:0];
        end else if (w_gnt0) begin
            o_mem_we   = i_m0_we;
            o_mem_addr = i_m0_addr;
            o_mem_wd   = i_m0_wd;
        end else if (w_gnt1) begin
            o_mem_we   = i_m1_we;
            o_mem_addr = i_m1_addr;
            o_mem_wd   = i_m1_wd;
        end
    end

    always_ff @(posedge clk) begin
        r_last_addr <= o_mem_addr;
        if (!resetn) begin
            r_state     <= ST_INIT;
            r_init_cnt  <= '0;
            r_init_done <= 1'b0;
            r_m0_rvalid <= 1'b0;
            r_m1_rvalid <= 1'b0;
        end else begin
            r_m0_rvalid <= w_gnt0 && !i_m0_we;
            r_m1_rvalid <= w_gnt1 && !i_m1_we;
            if (r_state == ST_INIT) begin
                r_init_cnt <= r_init_cnt + 1'b1;
                if (w_init_last) begin
                    r_state     <= ST_RUN;
                    r_init_done <= 1'b1;
                end
            end
        end
    end

    // A strobe that would land while reset is asserted is dropped, so the
    // outstanding read is never reported as delivered.
    assign o_m0_rvalid = r_m0_rvalid && resetn;
    assign o_m1_rvalid = r_m1_rvalid && resetn;
    assign o_rd_data   = i_mem_rd;
    assign o_init_done = r_init_done;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [8:0]  m0_addr, m1_addr;
    logic [31:0] m0_wd, m1_wd;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] rd_data, mem_wd, mem_rd;
    logic        mem_we, init_done;
    logic [8:0]  mem_addr;

    // Zero-init instance: only m0 is exercised.
    logic        z_req;
    logic        z_m0_gnt, z_m0_rvalid, z_m1_gnt, z_m1_rvalid, z_mem_we, z_init_done;
    logic [31:0] z_rd_data, z_mem_wd;
    logic [8:0]  z_mem_addr;

    logic [31:0] mem [512];

`ifdef DMEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    int nvec = 0;
    int nerr = 0;

    dmem_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .INIT_WORDS(16)) dut (
        .clk(clk), .resetn(resetn),
        .i_m0_req(m0_req), .i_m0_we(m0_we), .i_m0_addr(m0_addr), .i_m0_wd(m0_wd),
        .o_m0_gnt(m0_gnt), .o_m0_rvalid(m0_rvalid),
        .i_m1_req(m1_req), .i_m1_we(m1_we), .i_m1_addr(m1_addr), .i_m1_wd(m1_wd),
        .o_m1_gnt(m1_gnt), .o_m1_rvalid(m1_rvalid),
        .o_rd_data(rd_data), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wd(mem_wd), .i_mem_rd(mem_rd), .o_init_done(init_done)
    );

    dmem_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .INIT_WORDS(0)) dut_z (
        .clk(clk), .resetn(resetn),
        .i_m0_req(z_req), .i_m0_we(1'b0), .i_m0_addr(9'd0), .i_m0_wd(32'd0),
        .o_m0_gnt(z_m0_gnt), .o_m0_rvalid(z_m0_rvalid),
        .i_m1_req(1'b0), .i_m1_we(1'b0), .i_m1_addr(9'd0), .i_m1_wd(32'd0),
        .o_m1_gnt(z_m1_gnt), .o_m1_rvalid(z_m1_rvalid),
        .o_rd_data(z_rd_data), .o_mem_we(z_mem_we), .o_mem_addr(z_mem_addr),
        .o_mem_wd(z_mem_wd), .i_mem_rd(32'd0), .o_init_done(z_init_done)
    );

    // Single-port memory with registered read.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wd;
        mem_rd <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic [3:0] exp_g0;

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 32'hA5A50000 | i;
        mem[200] = 32'h12345678;
        exp_g0 = RR ? 4'b0101 : 4'b1111;   // bit c = m0 wins conflict cycle c
        resetn = 1'b0; z_req = 1'b0;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wd = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wd = '0;

        // Reset: request present but everything quiet
        repeat (2) @(negedge clk);
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 9'd33; m0_wd = '1;
        #1;
        chk("rst_gnt0", m0_gnt, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wd", mem_wd, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_rvalid0", m0_rvalid, 0);

        // Release: 16 zero-fill writes, no grants
        @(negedge clk);
        resetn = 1'b1; z_req = 1'b1;
        for (int k = 0; k < 16; k++) begin
            #1;
            chk($sformatf("init_we_%0d", k), mem_we, 1);
            chk($sformatf("init_addr_%0d", k), mem_addr, k);
            chk($sformatf("init_wd_%0d", k), mem_wd, 0);
            chk($sformatf("init_gnt_%0d", k), m0_gnt, 0);
            chk($sformatf("init_done_%0d", k), init_done, 0);
            chk($sformatf("z_mem_we_%0d", k), z_mem_we, 0);
            if (k == 0) begin
                chk("z_done_c0", z_init_done, 0);
                chk("z_gnt_c0", z_m0_gnt, 0);
            end
            if (k == 1) begin
                chk("z_done_c1", z_init_done, 1);
                chk("z_gnt_c1", z_m0_gnt, 1);
                z_req = 1'b0;
            end
            @(negedge clk);
        end
        m0_req = 1'b0;
        #1;
        chk("run_init_done", init_done, 1);
        chk("run_idle_we", mem_we, 0);

        // m1 write 0xDEADBEEF @5 then read @5
        @(negedge clk);
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 9'd5; m1_wd = 32'hDEADBEEF;
        #1;
        chk("m1w_gnt", m1_gnt, 1);
        chk("m1w_we", mem_we, 1);
        chk("m1w_addr", mem_addr, 5);
        chk("m1w_wd", mem_wd, 32'hDEADBEEF);
        @(negedge clk);
        m1_we = 1'b0;
        #1;
        chk("m1r_gnt", m1_gnt, 1);
        chk("m1r_we", mem_we, 0);
        chk("m1w_no_rvalid", m1_rvalid, 0);
        @(negedge clk);
        m1_req = 1'b0;
        #1;
        chk("m1r_rvalid", m1_rvalid, 1);
        chk("m1r_data", rd_data, 32'hDEADBEEF);
        chk("idle_addr_hold", mem_addr, 5);
        chk("idle_gnt1", m1_gnt, 0);

        // Conflict: m0 reads @3, m1 reads @200 for 4 cycles
        @(negedge clk);
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 9'd3;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 9'd200;
        #1;
        chk("m1_rvalid_1cyc", m1_rvalid, 0);
        for (int c = 0; c < 4; c++) begin
            if (c > 0) #1;
            chk($sformatf("cf_gnt0_%0d", c), m0_gnt, exp_g0[c]);
            chk($sformatf("cf_gnt1_%0d", c), m1_gnt, !exp_g0[c]);
            chk($sformatf("cf_addr_%0d", c), mem_addr, exp_g0[c] ? 3 : 200);
            if (c > 0) begin
                chk($sformatf("cf_rv0_%0d", c), m0_rvalid, exp_g0[c-1]);
                chk($sformatf("cf_rv1_%0d", c), m1_rvalid, !exp_g0[c-1]);
                chk($sformatf("cf_data_%0d", c), rd_data,
                    exp_g0[c-1] ? 32'h0 : 32'h12345678);
            end
            @(negedge clk);
        end
        m0_req = 1'b0;
        #1;
        chk("cf_rv0_4", m0_rvalid, exp_g0[3]);
        chk("cf_data_4", rd_data, exp_g0[3] ? 32'h0 : 32'h12345678);
        chk("m1_alone_gnt", m1_gnt, 1);
        @(negedge clk);
        m1_req = 1'b0;
        #1;
        chk("rd200_rvalid", m1_rvalid, 1);
        chk("rd200_data", rd_data, 32'h12345678);

        // m0 write @7, m1 reads @7 on the next cycle
        @(negedge clk);
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 9'd7; m0_wd = 32'hCAFE0007;
        #1;
        chk("alt_gnt0", m0_gnt, 1);
        @(negedge clk);
        m0_req = 1'b0;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 9'd7;
        #1;
        chk("alt_gnt1", m1_gnt, 1);
        chk("alt_no_rv0", m0_rvalid, 0);
        @(negedge clk);
        m1_req = 1'b0;
        #1;
        chk("alt_rv1", m1_rvalid, 1);
        chk("raw_data", rd_data, 32'hCAFE0007);

        // Reset the cycle after an m0 read grant
        @(negedge clk);
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 9'd200;
        #1;
        chk("mid_gnt0", m0_gnt, 1);
        @(negedge clk);
        m0_req = 1'b0; resetn = 1'b0;
        #1;
        chk("mid_rv0_drop", m0_rvalid, 0);
        chk("mid_we", mem_we, 0);
        @(negedge clk);
        #1;
        chk("mid_rv0_drop2", m0_rvalid, 0);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("reinit_we", mem_we, 1);
        chk("reinit_addr", mem_addr, 0);
        chk("reinit_done", init_done, 0);
        repeat (16) @(negedge clk);
        #1;
        chk("reinit_done_end", init_done, 1);

        // @5 cleared again, @200 preserved
        @(negedge clk);
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 9'd5;
        @(negedge clk);
        m1_addr = 9'd200;
        #1;
        chk("reinit_rv1", m1_rvalid, 1);
        chk("reinit_data5", rd_data, 0);
        @(negedge clk);
        m1_req = 1'b0;
        #1;
        chk("keep_data200", rd_data, 32'h12345678);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
